// File: rtl/delay_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : delay_line_ctrl
// Purpose  : Circular-buffer controller that sequences an external dual-port
//            RAM as a programmable sample delay line.
// Revision : 1.0 - initial release
// ============================================================================
module delay_line_ctrl #(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     en,
    input  logic [ADDRESS_WIDTH-1:0] offset,
    input  logic [DATA_WIDTH-1:0]    mic_in,
    input  logic [DATA_WIDTH-1:0]    ram_dout,
    output logic                     ram_wr_en,
    output logic                     ram_rd_en,
    output logic [ADDRESS_WIDTH-1:0] ram_wr_addr,
    output logic [ADDRESS_WIDTH-1:0] ram_rd_addr,
    output logic [DATA_WIDTH-1:0]    ram_din,
    output logic [DATA_WIDTH-1:0]    delayed_out,
    output logic                     out_valid,
    output logic                     running
);

    localparam logic [ADDRESS_WIDTH-1:0] c_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t                   r_state;
    logic [ADDRESS_WIDTH-1:0] r_wp;
    logic [ADDRESS_WIDTH-1:0] r_d_lat;
    logic [ADDRESS_WIDTH-1:0] r_fill_cnt;
    logic                     r_rd_pend;
    logic [DATA_WIDTH-1:0]    r_delayed;
    logic                     r_out_valid;

    logic                     w_accept;
    logic [ADDRESS_WIDTH-1:0] w_offset_eff;
    logic [ADDRESS_WIDTH-1:0] w_fill_next;

    // start wins over a coincident strobe, so neither write nor read happens
    assign w_accept     = en & ~start & (r_state != S_IDLE);
    assign w_offset_eff = (offset == '0) ? c_ONE : offset;
    assign w_fill_next  = r_fill_cnt + c_ONE;

    assign ram_wr_en   = w_accept;
    assign ram_rd_en   = en & ~start & (r_state == S_RUN);
    assign ram_wr_addr = r_wp;
    assign ram_rd_addr = r_wp - r_d_lat;
    assign ram_din     = mic_in;
    assign delayed_out = r_delayed;
    assign out_valid   = r_out_valid;
    assign running     = (r_state == S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wp        <= '0;
            r_d_lat     <= '0;
            r_fill_cnt  <= '0;
            r_rd_pend   <= 1'b0;
            r_delayed   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // RAM data arrives one cycle after the read; an in-flight read
            // survives a restart so its sample is still delivered
            r_rd_pend   <= ram_rd_en;
            r_out_valid <= r_rd_pend;
            if (r_rd_pend) begin
                r_delayed <= ram_dout;
            end

            if (start) begin
                r_d_lat    <= w_offset_eff;
                r_wp       <= '0;
                r_fill_cnt <= '0;
                r_state    <= S_FILL;
            end else if (w_accept) begin
                r_wp <= r_wp + c_ONE;
                if (r_state == S_FILL) begin
                    r_fill_cnt <= w_fill_next;
                    if (w_fill_next == r_d_lat) begin
                        r_state <= S_RUN;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_delay_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_line_ctrl
// Purpose  : Vector-table bench for delay_line_ctrl with behavioural RAMs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_delay_line_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       en = 1'b0;
    logic [8:0] offset = '0;
    logic [7:0] mic_in = '0;

    logic [7:0] ram_dout, ram_din, delayed_out;
    logic       ram_wr_en, ram_rd_en, out_valid, running;
    logic [8:0] ram_wr_addr, ram_rd_addr;

    logic [7:0] ram_dout4, ram_din4, delayed_out4;
    logic       ram_wr_en4, ram_rd_en4, out_valid4, running4;
    logic [3:0] ram_wr_addr4, ram_rd_addr4;

    logic [7:0] mem9 [512];
    logic [7:0] mem4 [16];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int st, en, off, mic;
        int ev, edo, erun, ewr, erd, ca, ewa, era;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    delay_line_ctrl #(.ADDRESS_WIDTH(9), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .en(en), .offset(offset),
        .mic_in(mic_in), .ram_dout(ram_dout), .ram_wr_en(ram_wr_en),
        .ram_rd_en(ram_rd_en), .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr),
        .ram_din(ram_din), .delayed_out(delayed_out), .out_valid(out_valid),
        .running(running)
    );

    delay_line_ctrl #(.ADDRESS_WIDTH(4), .DATA_WIDTH(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .en(en), .offset(offset[3:0]),
        .mic_in(mic_in), .ram_dout(ram_dout4), .ram_wr_en(ram_wr_en4),
        .ram_rd_en(ram_rd_en4), .ram_wr_addr(ram_wr_addr4), .ram_rd_addr(ram_rd_addr4),
        .ram_din(ram_din4), .delayed_out(delayed_out4), .out_valid(out_valid4),
        .running(running4)
    );

    always @(posedge clk) begin
        if (ram_wr_en) mem9[ram_wr_addr] <= ram_din;
        if (ram_rd_en) ram_dout <= mem9[ram_rd_addr];
        if (ram_wr_en4) mem4[ram_wr_addr4] <= ram_din4;
        if (ram_rd_en4) ram_dout4 <= mem4[ram_rd_addr4];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic add(input int st, en_i, off, mic, ev, edo, erun, ewr, erd, ca, ewa, era);
        vec_t v;
        v.st = st; v.en = en_i; v.off = off; v.mic = mic;
        v.ev = ev; v.edo = edo; v.erun = erun; v.ewr = ewr; v.erd = erd;
        v.ca = ca; v.ewa = ewa & 511; v.era = era & 511;
        vecs.push_back(v);
    endtask

    initial begin
        // ---- table: offset 3, offset 0, sparse offset 2, restart with en ----
        add(0, 1, 0, 99, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 3, 77, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 12; k++)   // offset changes here must be ignored
            add(0, 1, 7, k, int'(k >= 6), (k >= 6) ? k - 5 : 0, int'(k >= 4), 1,
                int'(k >= 4), 1, k - 1, k - 4);
        add(0, 0, 7, 0, 1, 8, 1, 0, 0, 0, 0, 0);
        add(0, 0, 7, 0, 1, 9, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0);

        add(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 6; k++)
            add(0, 1, 0, 20 + k, int'(k >= 4), (k >= 4) ? 17 + k : 9, int'(k >= 2), 1,
                int'(k >= 2), 1, k - 1, k - 2);
        add(0, 0, 0, 0, 1, 24, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 25, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 25, 1, 0, 0, 0, 0, 0);

        add(1, 0, 2, 0, 0, 25, 1, 0, 0, 0, 0, 0);
        for (int j = 1; j <= 6; j++) begin
            int lp, lj;
            lp = (j - 1 >= 3) ? 37 + j : 25;
            lj = (j >= 3) ? 38 + j : 25;
            add(0, 1, 2, 40 + j, 0, lp, int'(j >= 3), 1, int'(j >= 3), 1, j - 1, j - 3);
            add(0, 0, 2, 0, 0, lp, int'(j >= 2), 0, 0, 0, 0, 0);
            add(0, 0, 2, 0, int'(j >= 3), lj, int'(j >= 2), 0, 0, 0, 0, 0);
        end

        for (int m = 1; m <= 3; m++)
            add(0, 1, 2, 60 + m, int'(m == 3), (m == 3) ? 45 : 44, 1, 1, 1, 1, 5 + m, 3 + m);
        add(1, 1, 5, 99, 1, 46, 1, 0, 0, 1, 9, 7);
        add(0, 0, 5, 0, 1, 61, 0, 0, 0, 1, 0, -5);
        for (int n = 1; n <= 8; n++)
            add(0, 1, 5, 80 + n, int'(n >= 8), (n >= 8) ? 73 + n : 61, int'(n >= 6), 1,
                int'(n >= 6), 1, n - 1, n - 6);
        add(0, 0, 5, 0, 1, 82, 1, 0, 0, 0, 0, 0);
        add(0, 0, 5, 0, 1, 83, 1, 0, 0, 0, 0, 0);
        add(0, 0, 5, 0, 0, 83, 1, 0, 0, 0, 0, 0);

        // ---- reset state ----
        en = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_running", int'(running), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_dout", int'(delayed_out), 0);
        chk("rst_wr_en", int'(ram_wr_en), 0);
        chk("rst_rd_en", int'(ram_rd_en), 0);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;

        // ---- apply table ----
        foreach (vecs[i]) begin
            @(negedge clk);
            start  = vecs[i].st[0];
            en     = vecs[i].en[0];
            offset = 9'(vecs[i].off);
            mic_in = 8'(vecs[i].mic);
            #1;
            chk($sformatf("v%0d_valid", i), int'(out_valid), vecs[i].ev);
            chk($sformatf("v%0d_dout", i), int'(delayed_out), vecs[i].edo);
            chk($sformatf("v%0d_running", i), int'(running), vecs[i].erun);
            chk($sformatf("v%0d_wr_en", i), int'(ram_wr_en), vecs[i].ewr);
            chk($sformatf("v%0d_rd_en", i), int'(ram_rd_en), vecs[i].erd);
            if (vecs[i].ca != 0) begin
                chk($sformatf("v%0d_wr_addr", i), int'(ram_wr_addr), vecs[i].ewa);
                chk($sformatf("v%0d_rd_addr", i), int'(ram_rd_addr), vecs[i].era);
                chk($sformatf("v%0d_din", i), int'(ram_din), vecs[i].mic);
            end
        end

        // ---- wrap: 4-bit address instance, offset 15, 40 strobes ----
        @(negedge clk);
        start = 1'b1; en = 1'b0; offset = 9'd15;
        for (int i = 1; i <= 43; i++) begin
            @(negedge clk);
            start  = 1'b0;
            en     = (i <= 40);
            mic_in = 8'(100 + i);
            #1;
            if (i <= 40) begin
                chk("wrap_wr_addr4", int'(ram_wr_addr4), (i - 1) % 16);
                chk("wrap_running4", int'(running4), int'(i >= 16));
                chk("wrap_rd_en4", int'(ram_rd_en4), int'(i >= 16));
                if (i >= 16) chk("wrap_rd_addr4", int'(ram_rd_addr4), i % 16);
            end
            chk("wrap_valid4", int'(out_valid4), int'(i >= 18 && i <= 42));
            chk("wrap_valid9", int'(out_valid), int'(i >= 18 && i <= 42));
            if (i >= 18 && i <= 42) begin
                chk("wrap_dout4", int'(delayed_out4), 83 + i);
                chk("wrap_dout9", int'(delayed_out), 83 + i);
            end
        end

        // ---- asynchronous reset mid-RUN ----
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            en = 1'b1;
            mic_in = 8'(i);
        end
        @(posedge clk);
        #2;
        chk("pre_rst_valid", int'(out_valid), 1);
        chk("pre_rst_running", int'(running), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_running", int'(running), 0);
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_wr_en", int'(ram_wr_en), 0);
        chk("arst_rd_en", int'(ram_rd_en), 0);
        chk("arst_running4", int'(running4), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            en = 1'b1;
            #1;
            chk("idle_wr_en", int'(ram_wr_en), 0);
            chk("idle_running", int'(running), 0);
            chk("idle_valid", int'(out_valid), 0);
            chk("idle_dout", int'(delayed_out), 0);
        end
        @(negedge clk);
        start = 1'b1; offset = 9'd1; en = 1'b0;
        @(negedge clk);
        start = 1'b0; en = 1'b1; mic_in = 8'd5;
        #1;
        chk("restart_wr_en", int'(ram_wr_en), 1);
        chk("restart_wr_addr", int'(ram_wr_addr), 0);
        @(negedge clk);
        en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
